if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage for the LA32R 5-stage pipeline. Sends {pc, inst} to the decode stage.
//  Owns the PC register (with pre-IF next-PC selection) and drives the synchronous instruction SRAM.
//  Takes branch/jump redirects from decode (br_taken_cancel, br_target).
//  Holds the fetched word in a one-entry buffer while decode back-pressures.
// PARAMETERS
//  RESET_PC  32'h1c000000  first instruction address fetched after reset
//  NOP_INST  32'h03400000  andi r0,r0,0; replaces inst on a misaligned fetch
// PORTS
//  clk              in   1   clock
//  reset            in   1   reset, asynchronous, active-high
//  ds_allow_in      in   1   decode can accept an instruction this cycle
//  br_taken_cancel  in   1   decode redirect request (pulse, valid-qualified by decode)
//  br_target        in   32  redirect target address
//  inst_sram_en     out  1   SRAM read enable
//  inst_sram_we     out  4   SRAM byte write enable; constant 4'b0
//  inst_sram_addr   out  32  SRAM read address (next PC)
//  inst_sram_rdata  in   32  SRAM read data, valid 1 cycle after an enabled request
//  fs_to_ds_valid   out  1   {fs_pc, fs_inst} valid toward decode
//  fs_pc            out  32  PC of the instruction in IF
//  fs_inst          out  32  instruction word in IF
//  fs_adef          out  1   fs_pc[1:0]!=0 (fetch address error), qualified by fs_to_ds_valid
// BEHAVIOUR
//  - Reset state: fs_valid=0, fs_pc=RESET_PC-4, buf_valid=0, inst_buf=0.
//  - Outputs during reset: fs_to_ds_valid=0, fs_adef=0, inst_sram_en=0.
//  - First enabled request after reset release is RESET_PC; first valid at decode is the cycle after.
//  - fs_allow_in = ~fs_valid | ds_allow_in | br_taken_cancel.
//  - fs_ready_go = 1 (SRAM has fixed 1-cycle latency).
//  - Next PC:
//      seq_pc = fs_pc + 4, mod 2^32 (wraps 0xfffffffc -> 0x0)
//      nextpc = br_taken_cancel ? br_target : seq_pc
//  - SRAM drive: inst_sram_addr = nextpc; inst_sram_en = ~reset & fs_allow_in.
//  - Register update, on clk when fs_allow_in: fs_valid <= 1, fs_pc <= nextpc, buf_valid <= 0.
//  - Squash: fs_to_ds_valid = fs_valid & ~br_taken_cancel.
//      The wrong-path word in IF during a redirect is never handed to decode.
//      Redirect wins over stall: it is accepted even when ds_allow_in=0.
//  - Hold buffer:
//      if fs_valid & ~fs_allow_in & ~buf_valid: inst_buf <= inst_sram_rdata, buf_valid <= 1
//      fs_inst = buf_valid ? inst_buf : inst_sram_rdata
//      Stall of N>=1 cycles: fs_inst stays stable at the originally fetched word.
//  - Misaligned fetch: fs_adef = fs_to_ds_valid & (fs_pc[1:0]!=0); fs_inst = NOP_INST.
//      PC sequencing continues from the misaligned fs_pc.
//  - Decode-to-IF latency: redirect in cycle N -> fs_pc=br_target, fs_to_ds_valid=1 in cycle N+1.
//  - Asynchronous reset mid-stall or mid-redirect: state returns to reset values at once.
//      Any pending buffered word or redirect is dropped.
//  - Handshake: transfer to decode occurs when fs_to_ds_valid & ds_allow_in.
//      Exactly one transfer per fetched pc; no duplicates, no gaps.
// STRUCTURE
//  - Shared package (cpu_defs): RESET_PC, NOP_INST, PC width.
//      Same package feeds the decode stage's reset-vector usage.
//  - One sub-module, if_inst_buf: one-entry hold register.
//      Ports: clk, reset, capture, clear, din, dout, valid.
//  - PC/next-PC logic and handshake stay in if_stage.
// TESTING
//  1. Reset then free-run, ds_allow_in=1, SRAM returns addr as data:
//     SRAM addresses 0x1c000000, 0x1c000004, ... one per cycle;
//     decode sees matching pc/inst starting 1 cycle after the first request.
//  2. Stall: ds_allow_in=0 for 3 cycles while fs_pc=0x1c000008:
//     fs_pc and fs_inst hold the 0x1c000008 word (SRAM rdata perturbed meanwhile);
//     release -> next pc is 0x1c00000c, no duplicate transfer.
//  3. Redirect at fs_pc=0x1c000010 with target 0x1c000100:
//     fs_to_ds_valid=0 that cycle; next cycle fs_pc=0x1c000100, valid=1.
//  4. Redirect while ds_allow_in=0 and buf_valid=1, target 0x1c000200:
//     buffer cleared; next cycle fs_pc=0x1c000200, fs_inst from fresh rdata.
//  5. Redirect to 0x1c000102: fs_adef=1, fs_inst=0x03400000;
//     following pc 0x1c000106; wrap check: fs_pc=0xfffffffc -> next 0x00000000.
//  6. Assert reset mid-stall: outputs go to reset values immediately;
//     after release the first request is 0x1c000000.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: PC width, reset vector and the canonical NOP encoding.
// The decode stage takes its reset vector from here as well.
package cpu_defs;

    localparam int unsigned PC_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [PC_W-1:0]   RESET_VEC = 32'h1c00_0000;
    localparam logic [INST_W-1:0] NOP_WORD  = 32'h0340_0000;  // andi r0,r0,0

    function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    // Sequential successor; wraps naturally at 2^32.
    function automatic logic [PC_W-1:0] pc_seq(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry hold register for the fetched word while decode back-pressures.
// Clear has priority over capture.
module if_inst_buf #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic             clear,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             valid
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// LA32R instruction-fetch stage: owns the PC, drives the 1-cycle instruction SRAM,
// squashes on decode redirects and holds the fetched word across decode stalls.
module if_stage
    import cpu_defs::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC = RESET_VEC,
    parameter logic [INST_W-1:0] NOP_INST = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allow_in,
    input  logic        br_taken_cancel,
    input  logic [31:0] br_target,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef
);

    logic            fs_valid_q, fs_valid_d;
    logic [PC_W-1:0] fs_pc_q, fs_pc_d;
    logic            fs_allow_in;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] nextpc;
    logic            pc_bad;

    logic              buf_capture;
    logic              buf_valid;
    logic [INST_W-1:0] inst_buf;

    // A redirect always opens the stage so the wrong-path word is replaced at once.
    always_comb begin
        fs_allow_in = ~fs_valid_q | ds_allow_in | br_taken_cancel;
        seq_pc      = pc_seq(fs_pc_q);
        nextpc      = br_taken_cancel ? br_target : seq_pc;
        fs_valid_d  = fs_valid_q;
        fs_pc_d     = fs_pc_q;
        if (fs_allow_in) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= RESET_PC - PC_W'(4);
        end else begin
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
        end
    end

    // Capture only on the first stalled cycle; later rdata is no longer ours.
    assign buf_capture = fs_valid_q & ~fs_allow_in & ~buf_valid;

    if_inst_buf #(
        .Width (INST_W)
    ) u_inst_buf (
        .clk     (clk),
        .reset   (reset),
        .capture (buf_capture),
        .clear   (fs_allow_in),
        .din     (inst_sram_rdata),
        .dout    (inst_buf),
        .valid   (buf_valid)
    );

    always_comb begin
        pc_bad         = pc_misaligned(fs_pc_q);
        inst_sram_en   = ~reset & fs_allow_in;
        inst_sram_we   = 4'b0000;
        inst_sram_addr = nextpc;
        fs_to_ds_valid = fs_valid_q & ~br_taken_cancel;
        fs_pc          = fs_pc_q;
        fs_adef        = fs_to_ds_valid & pc_bad;
        if (pc_bad) begin
            fs_inst = NOP_INST;
        end else begin
            fs_inst = buf_valid ? inst_buf : inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomised plus directed bench for if_stage against a transaction-level fetch model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [31:0] NOP    = 32'h0340_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_allow_in = 1'b0;
    logic        br_taken_cancel = 1'b0;
    logic [31:0] br_target = '0;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = '0;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adef;

    logic perturb = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Model: IF either holds nothing, or holds one pc together with the word the SRAM gave for it.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_word;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allow_in     (ds_allow_in),
        .br_taken_cancel (br_taken_cancel),
        .br_target       (br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst),
        .fs_adef         (fs_adef)
    );

    always #5 clk = ~clk;

    // SRAM returns the address as data; when idle, optionally scramble rdata.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
        else if (perturb) inst_sram_rdata <= $urandom;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_accepts();
        return !m_valid || ds_allow_in || br_taken_cancel;
    endfunction

    function automatic logic [31:0] model_next();
        return br_taken_cancel ? br_target : m_pc + 32'd4;
    endfunction

    task automatic model_check();
        logic vld;
        vld = m_valid && !br_taken_cancel;
        check_eq("sram_en", inst_sram_en, !reset && model_accepts());
        check_eq("sram_we", inst_sram_we, 4'b0);
        check_eq("sram_addr", inst_sram_addr, model_next());
        check_eq("valid", fs_to_ds_valid, vld);
        check_eq("pc", fs_pc, m_pc);
        check_eq("adef", fs_adef, vld && (m_pc[1:0] != 2'b00));
        if (m_valid) check_eq("inst", fs_inst, (m_pc[1:0] != 2'b00) ? NOP : m_word);
    endtask

    task automatic drive(input logic a, input logic c, input logic [31:0] t, input logic p);
        @(negedge clk);
        ds_allow_in     = a;
        br_taken_cancel = c;
        br_target       = t;
        perturb         = p;
        #1;
        model_check();
    endtask

    task automatic tick();
        logic        acc;
        logic [31:0] np;
        acc = model_accepts();
        np  = model_next();
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_pc    = RST_PC - 32'd4;
        end else if (acc) begin
            m_valid = 1'b1;
            m_pc    = np;
            m_word  = np;
        end
    endtask

    initial begin
        m_valid = 1'b0;
        m_pc    = RST_PC - 32'd4;
        m_word  = '0;

        // Reset state and outputs held low during reset
        repeat (2) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        #2 reset = 1'b0;

        // Free run
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("first_req", inst_sram_addr, RST_PC);
        check_eq("first_en", inst_sram_en, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("first_pc", fs_pc, RST_PC);
        check_eq("first_valid", fs_to_ds_valid, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();

        // Three-cycle stall at 0x1c000008 with rdata scrambled
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            check_eq("stall_pc", fs_pc, 32'h1c00_0008);
            check_eq("stall_inst", fs_inst, 32'h1c00_0008);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("release_pc", fs_pc, 32'h1c00_0008);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("after_stall_pc", fs_pc, 32'h1c00_000c);
        tick();

        // Redirect at 0x1c000010
        drive(1'b1, 1'b1, 32'h1c00_0100, 1'b0);
        check_eq("redir_squash", fs_to_ds_valid, 1'b0);
        tick();

        // Stall to fill the buffer, then redirect while stalled
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("redir_pc", fs_pc, 32'h1c00_0100);
        check_eq("redir_valid", fs_to_ds_valid, 1'b1);
        tick();
        drive(1'b0, 1'b1, 32'h1c00_0200, 1'b1);
        check_eq("stall_redir_squash", fs_to_ds_valid, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("buf_cleared_pc", fs_pc, 32'h1c00_0200);
        check_eq("buf_cleared_inst", fs_inst, 32'h1c00_0200);
        tick();

        // Misaligned fetch and wrap
        drive(1'b1, 1'b1, 32'h1c00_0102, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("mis_adef", fs_adef, 1'b1);
        check_eq("mis_inst", fs_inst, NOP);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("mis_seq_pc", fs_pc, 32'h1c00_0106);
        tick();
        drive(1'b1, 1'b1, 32'hffff_fffc, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("wrap_from", fs_pc, 32'hffff_fffc);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("wrap_to", fs_pc, 32'h0000_0000);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        a, c;
            logic [31:0] t;
            a = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 9))
                0:       t = $urandom;
                1:       t = 32'hffff_fff0 | ($urandom & 32'hc);
                default: t = RST_PC | ($urandom & 32'h0000_fffc);
            endcase
            drive(a, c, t, 1'(($urandom & 1) != 0));
            tick();
        end

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_valid", fs_to_ds_valid, 1'b0);
        check_eq("rst_adef", fs_adef, 1'b0);
        check_eq("rst_en", inst_sram_en, 1'b0);
        check_eq("rst_pc", fs_pc, RST_PC - 32'd4);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        #2 reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("rst_first_req", inst_sram_addr, RST_PC);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("rst_first_pc", fs_pc, RST_PC);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
